// File: rtl/mmio_arbiter.sv
// Two-master (CPU data port m0, display fetcher m1) arbiter onto one MMIO slave port.
// Each access runs IDLE -> BUSY -> RESP; accesses that stall past TIMEOUT are aborted and logged in errno.
module mmio_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_memop,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        s_req,
    output logic        s_we,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [2:0]  s_memop,
    input  logic        s_ack,
    input  logic [31:0] s_rdata,
    input  logic        errno_clr,
    output logic        busy,
    output logic [31:0] errno
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] LP_MAX_BURST = 4'(MAX_BURST);
    localparam logic [7:0] LP_TCNT_LAST = 8'(TIMEOUT - 1);

    // m1 never writes, so a write owner is always m0
    function automatic logic [31:0] errno_code(input logic owner, input logic we);
        logic [31:0] code;
        if (owner) begin
            code = 32'd3;
        end else if (we) begin
            code = 32'd2;
        end else begin
            code = 32'd1;
        end
        return code;
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic [3:0]  r_streak, w_streak_nxt;
    logic [7:0]  r_tcnt, w_tcnt_nxt;
    logic        r_s_req, w_s_req_nxt;
    logic        r_s_we, w_s_we_nxt;
    logic [31:0] r_s_addr, w_s_addr_nxt;
    logic [31:0] r_s_wdata, w_s_wdata_nxt;
    logic [2:0]  r_s_memop, w_s_memop_nxt;
    logic        r_m0_ack, w_m0_ack_nxt, r_m0_err, w_m0_err_nxt;
    logic        r_m1_ack, w_m1_ack_nxt, r_m1_err, w_m1_err_nxt;
    logic [31:0] r_m0_rdata, w_m0_rdata_nxt, r_m1_rdata, w_m1_rdata_nxt;
    logic        r_busy, w_busy_nxt;
    logic [31:0] r_errno, w_errno_nxt;
    logic        w_pick_m0;
    logic        w_timeout;

    // Next-state, arbitration and response logic
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_streak_nxt   = r_streak;
        w_tcnt_nxt     = r_tcnt;
        w_s_req_nxt    = r_s_req;
        w_s_we_nxt     = r_s_we;
        w_s_addr_nxt   = r_s_addr;
        w_s_wdata_nxt  = r_s_wdata;
        w_s_memop_nxt  = r_s_memop;
        w_m0_ack_nxt   = r_m0_ack;
        w_m0_err_nxt   = r_m0_err;
        w_m0_rdata_nxt = r_m0_rdata;
        w_m1_ack_nxt   = r_m1_ack;
        w_m1_err_nxt   = r_m1_err;
        w_m1_rdata_nxt = r_m1_rdata;
        w_busy_nxt     = r_busy;
        w_timeout      = 1'b0;
        w_pick_m0      = m0_req && (!m1_req || (r_streak == LP_MAX_BURST));

        case (r_state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    w_s_req_nxt = 1'b1;
                    w_tcnt_nxt  = 8'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = ST_BUSY;
                    if (w_pick_m0) begin
                        w_owner_nxt   = 1'b0;
                        w_streak_nxt  = 4'd0;
                        w_s_we_nxt    = m0_we;
                        w_s_addr_nxt  = m0_addr;
                        w_s_wdata_nxt = m0_wdata;
                        w_s_memop_nxt = m0_memop;
                    end else begin
                        w_owner_nxt   = 1'b1;
                        w_streak_nxt  = m0_req ? (r_streak + 4'd1) : 4'd0;
                        w_s_we_nxt    = 1'b0;
                        w_s_addr_nxt  = m1_addr;
                        w_s_wdata_nxt = 32'd0;
                        w_s_memop_nxt = 3'b010;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                // an ack on the timeout edge completes normally
                if (s_ack) begin
                    w_s_req_nxt = 1'b0;
                    w_tcnt_nxt  = 8'd0;
                    w_state_nxt = ST_RESP;
                    if (r_owner) begin
                        w_m1_ack_nxt   = 1'b1;
                        w_m1_err_nxt   = 1'b0;
                        w_m1_rdata_nxt = s_rdata;
                    end else begin
                        w_m0_ack_nxt   = 1'b1;
                        w_m0_err_nxt   = 1'b0;
                        w_m0_rdata_nxt = s_rdata;
                    end
                end else if (r_tcnt == LP_TCNT_LAST) begin
                    w_timeout   = 1'b1;
                    w_s_req_nxt = 1'b0;
                    w_tcnt_nxt  = 8'd0;
                    w_state_nxt = ST_RESP;
                    if (r_owner) begin
                        w_m1_ack_nxt   = 1'b1;
                        w_m1_err_nxt   = 1'b1;
                        w_m1_rdata_nxt = 32'd0;
                    end else begin
                        w_m0_ack_nxt   = 1'b1;
                        w_m0_err_nxt   = 1'b1;
                        w_m0_rdata_nxt = 32'd0;
                    end
                end else begin
                    w_tcnt_nxt = r_tcnt + 8'd1;
                end
            end
            ST_RESP: begin
                w_m0_ack_nxt   = 1'b0;
                w_m0_err_nxt   = 1'b0;
                w_m0_rdata_nxt = 32'd0;
                w_m1_ack_nxt   = 1'b0;
                w_m1_err_nxt   = 1'b0;
                w_m1_rdata_nxt = 32'd0;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_s_req_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_timeout) begin
            w_errno_nxt = errno_code(r_owner, r_s_we);
        end else if (errno_clr) begin
            w_errno_nxt = 32'd0;
        end else begin
            w_errno_nxt = r_errno;
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_streak   <= 4'd0;
            r_tcnt     <= 8'd0;
            r_s_req    <= 1'b0;
            r_s_we     <= 1'b0;
            r_s_addr   <= 32'd0;
            r_s_wdata  <= 32'd0;
            r_s_memop  <= 3'd0;
            r_m0_ack   <= 1'b0;
            r_m0_err   <= 1'b0;
            r_m0_rdata <= 32'd0;
            r_m1_ack   <= 1'b0;
            r_m1_err   <= 1'b0;
            r_m1_rdata <= 32'd0;
            r_busy     <= 1'b0;
            r_errno    <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_streak   <= w_streak_nxt;
            r_tcnt     <= w_tcnt_nxt;
            r_s_req    <= w_s_req_nxt;
            r_s_we     <= w_s_we_nxt;
            r_s_addr   <= w_s_addr_nxt;
            r_s_wdata  <= w_s_wdata_nxt;
            r_s_memop  <= w_s_memop_nxt;
            r_m0_ack   <= w_m0_ack_nxt;
            r_m0_err   <= w_m0_err_nxt;
            r_m0_rdata <= w_m0_rdata_nxt;
            r_m1_ack   <= w_m1_ack_nxt;
            r_m1_err   <= w_m1_err_nxt;
            r_m1_rdata <= w_m1_rdata_nxt;
            r_busy     <= w_busy_nxt;
            r_errno    <= w_errno_nxt;
        end
    end

    assign s_req    = r_s_req;
    assign s_we     = r_s_we;
    assign s_addr   = r_s_addr;
    assign s_wdata  = r_s_wdata;
    assign s_memop  = r_s_memop;
    assign m0_ack   = r_m0_ack;
    assign m0_err   = r_m0_err;
    assign m0_rdata = r_m0_rdata;
    assign m1_ack   = r_m1_ack;
    assign m1_err   = r_m1_err;
    assign m1_rdata = r_m1_rdata;
    assign busy     = r_busy;
    assign errno    = r_errno;

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter (MAX_BURST=4, TIMEOUT=8) with a wait-state slave model.
module tb_mmio_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0;
    logic [2:0]  m0_memop = 3'd0;
    logic        m1_req = 1'b0;
    logic [31:0] m1_addr = 32'd0;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = 32'd0;
    logic        errno_clr = 1'b0;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, busy;
    logic [31:0] s_addr, s_wdata, errno;
    logic [2:0]  s_memop;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          slave_wait = 0;
    logic [31:0] slave_data = 32'd0;

    mmio_arbiter #(.MAX_BURST(4), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_memop(m0_memop), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .m1_err(m1_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_memop(s_memop),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .errno_clr(errno_clr), .busy(busy), .errno(errno)
    );

    always #5 clock = ~clock;

    // Slave: acks in BUSY cycle number slave_wait (0 = first); -1 never acks
    initial begin
        int scnt;
        scnt = 0;
        forever begin
            @(negedge clock);
            s_rdata = slave_data;
            if (s_req) begin
                s_ack = (scnt == slave_wait);
                scnt  = scnt + 1;
            end else begin
                s_ack = 1'b0;
                scnt  = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

    // cycles: negedges until the target ack (-1 if never); nreq: negedges with s_req high
    task automatic wait_ack(input logic which, output int cycles, output int nreq, output logic other);
        cycles = -1;
        nreq   = 0;
        other  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (s_req) nreq++;
            if (which ? m0_ack : m1_ack) other = 1'b1;
            if (which ? m1_ack : m0_ack) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        n_cmp++; if ({s_req, s_we, s_addr, s_wdata, s_memop} !== 70'd0) begin n_bad++; $display("FAIL rst_s_cmd: got %h want 0", {s_req, s_we, s_addr, s_wdata, s_memop}); end
        n_cmp++; if ({m0_ack, m0_err, m0_rdata} !== 34'd0) begin n_bad++; $display("FAIL rst_m0: got %h want 0", {m0_ack, m0_err, m0_rdata}); end
        n_cmp++; if ({m1_ack, m1_err, m1_rdata} !== 34'd0) begin n_bad++; $display("FAIL rst_m1: got %h want 0", {m1_ack, m1_err, m1_rdata}); end
        n_cmp++; if ({busy, errno} !== 33'd0) begin n_bad++; $display("FAIL rst_busy_errno: got %h want 0", {busy, errno}); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if ({s_req, busy} !== 2'b00) begin n_bad++; $display("FAIL rst_idle: got %b want 00", {s_req, busy}); end
    endtask

    task automatic test_m0_write();
        int c, nr;
        logic oth;
        slave_wait = 0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0010_0004; m0_wdata = 32'hDEADBEEF; m0_memop = 3'b010;
        @(negedge clock);
        n_cmp++; if ({s_req, s_we, busy} !== 3'b111) begin n_bad++; $display("FAIL m0w_req_we_busy: got %b want 111", {s_req, s_we, busy}); end
        n_cmp++; if (s_addr !== 32'h0010_0004) begin n_bad++; $display("FAIL m0w_addr: got %h want 00100004", s_addr); end
        n_cmp++; if (s_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL m0w_wdata: got %h want deadbeef", s_wdata); end
        wait_ack(1'b0, c, nr, oth);
        n_cmp++; if (c + 1 !== 2) begin n_bad++; $display("FAIL m0w_latency: got %0d want 2", c + 1); end
        n_cmp++; if ({m0_err, oth, s_req} !== 3'b000) begin n_bad++; $display("FAIL m0w_err_other_sreq: got %b want 000", {m0_err, oth, s_req}); end
        m0_req = 1'b0; m0_we = 1'b0;
        @(negedge clock);
        n_cmp++; if ({m0_ack, busy} !== 2'b00) begin n_bad++; $display("FAIL m0w_single_pulse: got %b want 00", {m0_ack, busy}); end
    endtask

    task automatic test_m1_read();
        int c, nr;
        logic oth;
        slave_wait = 3; slave_data = 32'h1234_5678;
        m1_req = 1'b1; m1_addr = 32'h0020_0040;
        wait_ack(1'b1, c, nr, oth);
        n_cmp++; if (c !== 5) begin n_bad++; $display("FAIL m1r_latency: got %0d want 5", c); end
        n_cmp++; if (m1_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL m1r_rdata: got %h want 12345678", m1_rdata); end
        n_cmp++; if ({m1_err, oth, m0_ack} !== 3'b000) begin n_bad++; $display("FAIL m1r_err_m0ack: got %b want 000", {m1_err, oth, m0_ack}); end
        n_cmp++; if ({s_we, s_wdata, s_memop} !== {1'b0, 32'd0, 3'b010}) begin n_bad++; $display("FAIL m1r_cmd: got %h want 2", {s_we, s_wdata, s_memop}); end
        m1_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_arbitration();
        logic exp_ord [6];
        logic got_ord [6];
        logic prev;
        int   ng;
        exp_ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) got_ord[i] = 1'bx;
        ng = 0; prev = 1'b0; slave_wait = 0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_addr = 32'h0000_0200;
        for (int t = 0; t < 40; t++) begin
            @(negedge clock);
            if (s_req && !prev && ng < 6) begin
                got_ord[ng] = (s_addr == 32'h0000_0200);
                if (ng == 3) begin
                    n_cmp++; if (dut.r_streak !== 4'd4) begin n_bad++; $display("FAIL arb_streak4: got %0d want 4", dut.r_streak); end
                end
                if (ng == 4) begin
                    n_cmp++; if (dut.r_streak !== 4'd0) begin n_bad++; $display("FAIL arb_streak0: got %0d want 0", dut.r_streak); end
                end
                ng++;
            end
            prev = s_req;
            if (ng == 6 && m1_ack) break;
        end
        m0_req = 1'b0; m1_req = 1'b0;
        n_cmp++; if (ng !== 6) begin n_bad++; $display("FAIL arb_grants: got %0d want 6", ng); end
        for (int i = 0; i < 6; i++) begin
            n_cmp++; if (got_ord[i] !== exp_ord[i]) begin n_bad++; $display("FAIL arb_order[%0d]: got m%b want m%b", i, got_ord[i], exp_ord[i]); end
        end
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arb_idle: got %b want 0", busy); end
    endtask

    task automatic test_timeout_read();
        int c, nr;
        logic oth;
        n_cmp++; if (errno !== 32'd0) begin n_bad++; $display("FAIL to_errno_pre: got %0d want 0", errno); end
        slave_wait = -1; slave_data = 32'hA5A5_A5A5;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0300;
        wait_ack(1'b0, c, nr, oth);
        n_cmp++; if (c !== 9) begin n_bad++; $display("FAIL to_latency: got %0d want 9", c); end
        n_cmp++; if (nr !== 8) begin n_bad++; $display("FAIL to_busy_cycles: got %0d want 8", nr); end
        n_cmp++; if ({m0_err, m0_rdata} !== {1'b1, 32'd0}) begin n_bad++; $display("FAIL to_err_rdata: got %h want 100000000", {m0_err, m0_rdata}); end
        n_cmp++; if (errno !== 32'd1) begin n_bad++; $display("FAIL to_errno: got %0d want 1", errno); end
        m0_req = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (errno !== 32'd1) begin n_bad++; $display("FAIL to_errno_hold: got %0d want 1", errno); end
        errno_clr = 1'b1;
        @(negedge clock);
        errno_clr = 1'b0;
        n_cmp++; if (errno !== 32'd0) begin n_bad++; $display("FAIL to_errno_clr: got %0d want 0", errno); end
    endtask

    task automatic test_clr_collision();
        int c, nr;
        logic oth;
        slave_wait = -1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0304; m0_wdata = 32'h0000_0001;
        repeat (8) @(negedge clock);
        errno_clr = 1'b1;
        wait_ack(1'b0, c, nr, oth);
        errno_clr = 1'b0;
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL clr_latency: got %0d want 1", c); end
        n_cmp++; if ({m0_err, errno} !== {1'b1, 32'd2}) begin n_bad++; $display("FAIL clr_errno: got %h want 100000002", {m0_err, errno}); end
        m0_req = 1'b0; m0_we = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_ack_on_timeout();
        int c, nr;
        logic oth;
        slave_wait = 7; slave_data = 32'hCAFE_0001;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0308;
        wait_ack(1'b0, c, nr, oth);
        n_cmp++; if (c !== 9) begin n_bad++; $display("FAIL edge_latency: got %0d want 9", c); end
        n_cmp++; if ({m0_err, m0_rdata} !== {1'b0, 32'hCAFE_0001}) begin n_bad++; $display("FAIL edge_err_rdata: got %h want 0cafe0001", {m0_err, m0_rdata}); end
        n_cmp++; if (errno !== 32'd2) begin n_bad++; $display("FAIL edge_errno: got %0d want 2", errno); end
        m0_req = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_busy();
        int   c, nr;
        logic oth;
        logic seen;
        slave_wait = -1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_030C;
        @(negedge clock);
        n_cmp++; if ({busy, s_req} !== 2'b11) begin n_bad++; $display("FAIL rb_busy: got %b want 11", {busy, s_req}); end
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++; if ({s_req, busy, errno} !== 34'd0) begin n_bad++; $display("FAIL rb_async_clear: got %h want 0", {s_req, busy, errno}); end
        n_cmp++; if ({m0_ack, m0_err, m0_rdata, m1_ack} !== 35'd0) begin n_bad++; $display("FAIL rb_outputs: got %h want 0", {m0_ack, m0_err, m0_rdata, m1_ack}); end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (m0_ack || busy) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rb_no_ack: got %b want 0", seen); end
        reset = 1'b1; slave_wait = 0;
        wait_ack(1'b0, c, nr, oth);
        n_cmp++; if (c !== 2) begin n_bad++; $display("FAIL rb_regrant_latency: got %0d want 2", c); end
        n_cmp++; if ({m0_err, errno} !== 33'd0) begin n_bad++; $display("FAIL rb_regrant_err: got %h want 0", {m0_err, errno}); end
        m0_req = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_m0_write();
        test_m1_read();
        test_arbitration();
        test_timeout_read();
        test_clr_collision();
        test_ack_on_timeout();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
